// File: rtl/baud_tick_generator_prog.sv
// Programmable baud/oversample tick generator with a fractional divisor.
// The period is active_int cycles, stretched by one cycle whenever the
// fractional accumulator carries. A new divisor is staged in a shadow
// register and takes effect only at a period boundary, on a sync_clr, or
// immediately while the generator is disabled. This keeps every period whole.
module baud_tick_generator_prog #(
  parameter int DIV_W        = 16,
  parameter int FRAC_W       = 4,
  parameter int OVERSAMPLE   = 16,
  parameter int DEFAULT_DIV  = 163,
  parameter int DEFAULT_FRAC = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              sync_clr,
  input  logic              load,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              os_tick,
  output logic              baud_tick,
  output logic              cfg_err
);

  localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OS_W-1:0]   OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(DEFAULT_DIV);
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEFAULT_FRAC);
  localparam logic [DIV_W-1:0]  MIN_DIV  = DIV_W'(2);

  // Cycle counter is one bit wider than the divisor so that a stretched
  // period of 2^DIV_W cycles (max divisor plus carry) still fits.
  logic [DIV_W:0]      cnt_q, cnt_d;
  logic [FRAC_W-1:0]   acc_q, acc_d;
  logic [OS_W-1:0]     os_cnt_q, os_cnt_d;
  logic [DIV_W-1:0]    act_int_q, act_int_d;
  logic [FRAC_W-1:0]   act_frac_q, act_frac_d;
  logic [DIV_W-1:0]    shd_int_q, shd_int_d;
  logic [FRAC_W-1:0]   shd_frac_q, shd_frac_d;
  logic                pend_q, pend_d;
  logic                os_tick_q, os_tick_d;
  logic                baud_q, baud_d;
  logic                cfg_err_q, cfg_err_d;

  logic [FRAC_W:0]     acc_sum;
  logic [DIV_W:0]      last_cnt;
  logic                period_end;
  logic                load_ok;

  // Period arithmetic: carry of the fractional sum extends this period by one.
  always_comb begin
    acc_sum    = {1'b0, acc_q} + {1'b0, act_frac_q};
    last_cnt   = {1'b0, act_int_q} + {{DIV_W{1'b0}}, acc_sum[FRAC_W]} - (DIV_W+1)'(1);
    period_end = (cnt_q == last_cnt);
    load_ok    = load && (div_int >= MIN_DIV);
  end

  // Next-state logic for counters, divisor staging and tick outputs.
  always_comb begin
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    os_cnt_d   = os_cnt_q;
    act_int_d  = act_int_q;
    act_frac_d = act_frac_q;
    shd_int_d  = shd_int_q;
    shd_frac_d = shd_frac_q;
    pend_d     = pend_q;
    os_tick_d  = 1'b0;
    baud_d     = 1'b0;
    cfg_err_d  = cfg_err_q;

    // A rejected load leaves the shadow alone and raises the sticky error.
    if (load) begin
      cfg_err_d = !load_ok;
    end
    if (load_ok) begin
      shd_int_d  = div_int;
      shd_frac_d = div_frac;
      pend_d     = 1'b1;
    end

    if (sync_clr) begin
      cnt_d    = '0;
      acc_d    = '0;
      os_cnt_d = '0;
      if (load_ok) begin
        act_int_d  = div_int;
        act_frac_d = div_frac;
        pend_d     = 1'b0;
      end else if (pend_q) begin
        act_int_d  = shd_int_q;
        act_frac_d = shd_frac_q;
        pend_d     = 1'b0;
      end
    end else if (enable) begin
      if (period_end) begin
        cnt_d     = '0;
        acc_d     = acc_sum[FRAC_W-1:0];
        os_tick_d = 1'b1;
        if (os_cnt_q == OS_LAST) begin
          os_cnt_d = '0;
          baud_d   = 1'b1;
        end else begin
          os_cnt_d = os_cnt_q + OS_W'(1);
        end
        // Swap divisors only here so the finished period used the old one;
        // a load on this same edge stays pending for the next boundary.
        if (pend_q) begin
          act_int_d  = shd_int_q;
          act_frac_d = shd_frac_q;
          pend_d     = load_ok;
        end
      end else begin
        cnt_d = cnt_q + (DIV_W+1)'(1);
      end
    end else begin
      // Idle: nothing is mid-period, so a staged divisor can apply at once.
      if (pend_q) begin
        act_int_d  = shd_int_q;
        act_frac_d = shd_frac_q;
        pend_d     = load_ok;
      end
    end
  end

  // State registers with asynchronous active-low reset to the default divisor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      os_cnt_q   <= '0;
      act_int_q  <= DEF_INT;
      act_frac_q <= DEF_FRAC;
      shd_int_q  <= DEF_INT;
      shd_frac_q <= DEF_FRAC;
      pend_q     <= 1'b0;
      os_tick_q  <= 1'b0;
      baud_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      os_cnt_q   <= os_cnt_d;
      act_int_q  <= act_int_d;
      act_frac_q <= act_frac_d;
      shd_int_q  <= shd_int_d;
      shd_frac_q <= shd_frac_d;
      pend_q     <= pend_d;
      os_tick_q  <= os_tick_d;
      baud_q     <= baud_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign os_tick   = os_tick_q;
  assign baud_tick = baud_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_baud_tick_generator_prog.sv
// Directed bench for baud_tick_generator_prog. Expected tick cycles are
// pushed to queues as each step is set up; a negedge monitor pops and
// compares them against the cycle on which each tick actually appears.
module tb_baud_tick_generator_prog;

  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;
  localparam int OS     = 16;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic              sync_clr;
  logic              load;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              os_tick;
  logic              baud_tick;
  logic              cfg_err;

  int errors = 0;
  int checks = 0;
  int exp_os_n = 0;
  logic [31:0] cyc = '0;
  logic [31:0] exp_os_q[$];
  logic [31:0] exp_baud_q[$];
  logic        prev_os = 1'b0;
  logic [31:0] t0;

  baud_tick_generator_prog #(
    .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVERSAMPLE(OS),
    .DEFAULT_DIV(163), .DEFAULT_FRAC(12)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sync_clr(sync_clr),
    .load(load), .div_int(div_int), .div_frac(div_frac),
    .os_tick(os_tick), .baud_tick(baud_tick), .cfg_err(cfg_err)
  );

  // Clock and edge counter.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: outputs sampled at negedge, tagged with the edge count.
  always @(negedge clk) begin
    while (exp_os_q.size() != 0 && exp_os_q[0] < cyc) begin
      chk("os_tick_missed", cyc, exp_os_q[0]);
      void'(exp_os_q.pop_front());
    end
    while (exp_baud_q.size() != 0 && exp_baud_q[0] < cyc) begin
      chk("baud_tick_missed", cyc, exp_baud_q[0]);
      void'(exp_baud_q.pop_front());
    end
    if (os_tick === 1'b1) begin
      chk("os_tick_gap", prev_os, 0);
      if (exp_os_q.size() == 0) chk("os_tick_unexpected", cyc, -1);
      else chk("os_tick_cycle", cyc, exp_os_q.pop_front());
    end
    if (baud_tick === 1'b1) begin
      chk("baud_with_os", os_tick, 1);
      if (exp_baud_q.size() == 0) chk("baud_tick_unexpected", cyc, -1);
      else chk("baud_tick_cycle", cyc, exp_baud_q.pop_front());
    end
    prev_os = os_tick;
  end

  // Driver tasks: all called at a negedge, inputs sampled on the next posedge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load(input int d, input int f);
    load = 1'b1;
    div_int = DIV_W'(d);
    div_frac = FRAC_W'(f);
    tick(1);
    load = 1'b0;
  endtask

  task automatic pulse_clr();
    sync_clr = 1'b1;
    tick(1);
    sync_clr = 1'b0;
    exp_os_n = 0;
  endtask

  task automatic push_os(input logic [31:0] c);
    exp_os_q.push_back(c);
    if (exp_os_n % OS == OS - 1) exp_baud_q.push_back(c);
    exp_os_n++;
  endtask

  task automatic push_periodic(input logic [31:0] first, input int period, input int n);
    for (int i = 0; i < n; i++) push_os(first + 32'(i * period));
  endtask

  task automatic step_done();
    chk("os_queue_drained", exp_os_q.size(), 0);
    chk("baud_queue_drained", exp_baud_q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; sync_clr = 1'b0; load = 1'b0;
    div_int = '0; div_frac = '0;
    tick(3);
    chk("reset_os_tick", os_tick, 0);
    chk("reset_baud_tick", baud_tick, 0);
    chk("reset_cfg_err", cfg_err, 0);
    rst_n = 1'b1;
    tick(1);

    // div 4, frac 0: os_tick every 4, baud every 64.
    pulse_load(4, 0);
    tick(1);
    pulse_clr();
    t0 = cyc; enable = 1'b1;
    push_periodic(t0 + 4, 4, 32);
    tick(130);
    enable = 1'b0; tick(2); step_done();

    // div 4, frac 8: periods 4,5,4,5 -> 16 ticks in 72 cycles.
    pulse_load(4, 8);
    pulse_clr();
    t0 = cyc; enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      t0 = t0 + ((i % 2 == 0) ? 32'd4 : 32'd5);
      push_os(t0);
    end
    tick(72);
    enable = 1'b0; tick(2); step_done();

    // div 10 running, load 3 four cycles into a period: glitch-free switch.
    pulse_load(10, 0);
    pulse_clr();
    t0 = cyc; enable = 1'b1;
    push_os(t0 + 10); push_os(t0 + 20); push_os(t0 + 30);
    push_periodic(t0 + 33, 3, 4);
    tick(24);
    pulse_load(3, 0);
    tick(17);
    enable = 1'b0; tick(2); step_done();

    // Rejected load keeps period 3; valid load 6 while idle applies next edge.
    pulse_clr();
    pulse_load(1, 0);
    chk("cfg_err_after_bad_load", cfg_err, 1);
    t0 = cyc; enable = 1'b1;
    push_periodic(t0 + 3, 3, 2);
    tick(6);
    enable = 1'b0;
    chk("cfg_err_sticky", cfg_err, 1);
    pulse_load(6, 0);
    chk("cfg_err_after_good_load", cfg_err, 0);
    tick(1);
    t0 = cyc; enable = 1'b1;
    push_periodic(t0 + 6, 6, 2);
    tick(12);
    enable = 1'b0; tick(2); step_done();

    // div 8 to cnt=5, os_cnt=9, pending div 4, then sync_clr.
    pulse_load(8, 0);
    pulse_clr();
    t0 = cyc; enable = 1'b1;
    push_periodic(t0 + 8, 8, 9);
    tick(74);
    pulse_load(4, 0);
    tick(2);
    pulse_clr();
    push_periodic(t0 + 82, 4, 16);
    tick(64);
    enable = 1'b0; tick(2); step_done();

    // Enable low for 7 cycles mid-period, then async reset mid-period.
    pulse_load(0, 0);
    chk("cfg_err_zero_div", cfg_err, 1);
    t0 = cyc; enable = 1'b1;
    push_os(t0 + 4); push_os(t0 + 8); push_os(t0 + 19); push_os(t0 + 23);
    tick(10);
    enable = 1'b0;
    tick(7);
    enable = 1'b1;
    tick(8);
    step_done();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_os_tick", os_tick, 0);
    chk("async_rst_baud_tick", baud_tick, 0);
    chk("async_rst_cfg_err", cfg_err, 0);
    enable = 1'b0;
    tick(3);
    rst_n = 1'b1;
    exp_os_n = 0;
    t0 = cyc; enable = 1'b1;
    push_os(t0 + 163); push_os(t0 + 327);
    tick(327);
    enable = 1'b0; tick(2); step_done();

    // sync_clr with a valid load activates 5 at once; two loads, last wins.
    t0 = cyc;
    enable = 1'b1; sync_clr = 1'b1; load = 1'b1;
    div_int = DIV_W'(5); div_frac = '0;
    tick(1);
    sync_clr = 1'b0; load = 1'b0; exp_os_n = 0;
    push_periodic(t0 + 6, 5, 3);
    push_periodic(t0 + 19, 3, 2);
    tick(12);
    pulse_load(9, 0);
    pulse_load(3, 0);
    tick(7);
    enable = 1'b0; tick(2); step_done();
    chk("cfg_err_final", cfg_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/baud_tick_generator_prog.md
BAUD_TICK_GENERATOR_PROG -- requirements
Module: baud_tick_generator_prog

Interface
REQ-001 Parameter DIV_W, default 16, bit width of the integer divisor.
REQ-002 Parameter FRAC_W, default 4, bit width of the fractional divisor (units of 1/2^FRAC_W clock).
REQ-003 Parameter OVERSAMPLE, default 16, number of os_tick pulses per baud_tick; legal range 1..256.
REQ-004 Parameter DEFAULT_DIV, default 163, integer divisor loaded at reset; legal values are >= 2.
REQ-005 Parameter DEFAULT_FRAC, default 12, fractional divisor loaded at reset.
REQ-006 clk  input  1  system clock; all logic on the rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset; this is the only reset.
REQ-008 enable  input  1  high = generator runs; low = counters hold and ticks stay 0.
REQ-009 sync_clr  input  1  single-cycle pulse that restarts the tick phase (RX start-bit alignment).
REQ-010 load  input  1  single-cycle pulse that captures div_int/div_frac into the shadow divisor.
REQ-011 div_int  input  DIV_W  requested integer divisor.
REQ-012 div_frac  input  FRAC_W  requested fractional divisor.
REQ-013 os_tick  output  1  registered one-cycle oversample tick.
REQ-014 baud_tick  output  1  registered one-cycle tick every OVERSAMPLE os_ticks, coincident with an os_tick.
REQ-015 cfg_err  output  1  sticky flag set when a load is rejected.

Function
REQ-016 Internal state: cnt (DIV_W+1 bits), acc (FRAC_W bits), os_cnt (ceil(log2(OVERSAMPLE)) bits, min 1), active divisor, shadow divisor, pending flag.
REQ-017 Period length P = active_int + ext; ext = carry out of (acc + active_frac); arithmetic is unsigned and must not overflow at active_int = 2^DIV_W-1.
REQ-018 On each clock with enable=1 and no sync_clr: if cnt == P-1, then cnt <= 0, os_tick <= 1, acc <= (acc + active_frac) mod 2^FRAC_W; otherwise cnt <= cnt+1, os_tick <= 0.
REQ-019 With frac=0, os_tick is high for exactly one cycle in every active_int cycles; the first os_tick is high in the active_int-th cycle after enable first rises.
REQ-020 When os_tick is set: if os_cnt == OVERSAMPLE-1, then os_cnt <= 0 and baud_tick <= 1 in the same cycle as os_tick; otherwise os_cnt <= os_cnt+1. baud_tick is 0 in all other cycles.
REQ-021 enable=0: cnt, acc and os_cnt hold; os_tick and baud_tick are 0 on the next edge; counting resumes seamlessly when enable returns to 1.
REQ-022 load with div_int >= 2: shadow <= inputs, pending <= 1, and cfg_err <= 0.
REQ-023 load with div_int < 2: shadow and pending are unchanged, and cfg_err <= 1; cfg_err holds until the next valid load or reset.
REQ-024 Pending divisor, enable=1: copied to the active divisor at the period boundary (the edge where os_tick is set), then pending <= 0; the period in progress completes with the old divisor (glitch-free).
REQ-025 Pending divisor, enable=0: copied to the active divisor on the next edge.
REQ-026 sync_clr: cnt, acc and os_cnt <= 0, os_tick and baud_tick <= 0, any pending divisor becomes active; sync_clr overrides enable.
REQ-027 sync_clr and valid load in the same cycle: the new inputs become active directly on that edge, with counters cleared.
REQ-028 A second load before a pending divisor is applied overwrites the shadow; the last valid load wins.
REQ-029 Ticks never assert for two consecutive cycles, because P >= 2.

Reset
REQ-030 rst_n low, asynchronously: cnt, acc, os_cnt, pending, os_tick, baud_tick and cfg_err <= 0; active and shadow divisors <= DEFAULT_DIV/DEFAULT_FRAC.
REQ-031 rst_n asserted mid-period clears all state immediately; after release, timing restarts per REQ-019.

Verification
REQ-032 OVERSAMPLE=16, load div_int=4, frac=0, enable=1 -> os_tick every 4 cycles, baud_tick every 64 cycles, coincident with every 16th os_tick.
REQ-033 FRAC_W=4, div_int=4, frac=8 -> periods alternate 4,5,4,5...; exactly 16 os_ticks in 72 cycles.
REQ-034 div 10 running, load div_int=3 at cycle 4 of a period -> that period ends at 10 cycles, then periods are 3; no short or double tick.
REQ-035 load div_int=1 -> cfg_err=1 and period unchanged; then load div_int=6 -> cfg_err=0 and period 6.
REQ-036 sync_clr at cnt=5, os_cnt=9 -> next os_tick 4 cycles after the clear (div 4), next baud_tick after 16 further os_ticks.
REQ-037 enable low for 7 cycles mid-period, then rst_n pulsed low mid-period -> hold with no ticks, then all outputs 0 and default divisor 163 (frac 12) active.
